// File: rtl/uart_trx_core.sv
// Full-duplex 8N1 UART transceiver core.
// RX path: a two-flop synchroniser, a falling-edge detector and a byte receiver.
// TX path: sends 1..MAX_BYTES bytes of a latched word, byte 0 first, with no gap between bytes.
module uart_trx_core #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MAX_BYTES    = 8
) (
    input  logic                   CLK100MHZ,
    input  logic                   rst_n,
    input  logic                   rx_pin_in,
    output logic [7:0]             rx_data,
    output logic                   rx_done_sig,
    output logic                   h2l_sig,
    input  logic                   tx_sig,
    input  logic [MAX_BYTES*8-1:0] tx_data,
    input  logic [3:0]             len,
    output logic                   tx_pin_out,
    output logic                   tx_busy,
    output logic                   tx_done_sig
);

    localparam int unsigned DataW = MAX_BYTES * 8;
    localparam int unsigned CntW  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] HalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]      MaxLen  = 4'(MAX_BYTES);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    // ---------------------------------------------------------------- RX path
    logic            sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_done_q, rx_done_d;
    logic            h2l;

    assign h2l = hist_q & ~sync2_q;

    // RX next-state: synchroniser shift, start validation, mid-bit sampling, stop check
    always_comb begin
        sync1_d    = rx_pin_in;
        sync2_d    = sync1_q;
        hist_d     = sync2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_done_d  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (h2l) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfEnd) begin
                    rx_cnt_d   = '0;
                    // Line back high by mid start bit means the edge was a glitch
                    rx_state_d = sync2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitEnd) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    // A low stop bit is a framing error: drop the byte silently
                    if (sync2_q) begin
                        rx_data_d = rx_shift_q;
                        rx_done_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    // RX state registers; synchroniser presets to idle-high
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            hist_q     <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            hist_q     <= hist_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_done_q  <= rx_done_d;
        end
    end

    // ---------------------------------------------------------------- TX path
    logic             tx_sig_q, tx_sig_d;
    tx_state_e        tx_state_q, tx_state_d;
    logic [CntW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [3:0]       tx_byte_q, tx_byte_d;
    logic [3:0]       tx_len_q, tx_len_d;
    logic [DataW-1:0] tx_shift_q, tx_shift_d;
    logic             tx_pin_q, tx_pin_d;
    logic             tx_done_q, tx_done_d;
    logic             tx_req;

    assign tx_req = tx_sig & ~tx_sig_q;

    // TX next-state: accept on request edge when idle, then shift out framed bytes
    always_comb begin
        tx_sig_d   = tx_sig;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        tx_len_d   = tx_len_q;
        tx_shift_d = tx_shift_q;
        tx_pin_d   = tx_pin_q;
        tx_done_d  = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_pin_d = 1'b1;
                if (tx_req) begin
                    tx_shift_d = tx_data;
                    tx_len_d   = (len == 4'd0 || len > MaxLen) ? MaxLen : len;
                    tx_byte_d  = '0;
                    tx_cnt_d   = '0;
                    tx_pin_d   = 1'b0;
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_pin_d   = tx_shift_q[0];
                    tx_shift_d = tx_shift_q >> 1;
                    tx_state_d = TxData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_pin_d   = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_pin_d   = tx_shift_q[0];
                        tx_shift_d = tx_shift_q >> 1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                if (tx_cnt_q == BitEnd) begin
                    tx_cnt_d = '0;
                    if (tx_byte_q == tx_len_q - 4'd1) begin
                        tx_state_d = TxIdle;
                        tx_done_d  = 1'b1;
                    end else begin
                        tx_byte_d  = tx_byte_q + 1'b1;
                        tx_pin_d   = 1'b0;
                        tx_state_d = TxStart;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // TX state registers; line forced idle-high on reset
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            tx_sig_q   <= 1'b0;
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            tx_len_q   <= '0;
            tx_shift_q <= '0;
            tx_pin_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            tx_sig_q   <= tx_sig_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            tx_len_q   <= tx_len_d;
            tx_shift_q <= tx_shift_d;
            tx_pin_q   <= tx_pin_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_done_sig = rx_done_q;
    assign h2l_sig     = h2l;
    assign tx_pin_out  = tx_pin_q;
    assign tx_busy     = (tx_state_q != TxIdle);
    assign tx_done_sig = tx_done_q;

endmodule

// File: tb/tb_uart_trx_core.sv
// Directed bench for uart_trx_core with a short bit period (16 clocks per bit).
module tb_uart_trx_core;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;
    logic        rx_line;
    logic [7:0]  rx_data;
    logic        rx_done_sig, h2l_sig;
    logic        tx_sig = 1'b0;
    logic [63:0] tx_data = '0;
    logic [3:0]  len = 4'd1;
    logic        tx_pin_out, tx_busy, tx_done_sig;

    int n_vec = 0;
    int n_err = 0;
    int rx_done_cnt = 0;
    int h2l_cnt = 0;
    int tx_done_cnt = 0;

    always #5 clk = ~clk;

    assign rx_line = loop_en ? tx_pin_out : rx_drv;

    uart_trx_core #(.CLKS_PER_BIT(CPB), .MAX_BYTES(8)) dut (
        .CLK100MHZ  (clk),
        .rst_n      (rst_n),
        .rx_pin_in  (rx_line),
        .rx_data    (rx_data),
        .rx_done_sig(rx_done_sig),
        .h2l_sig    (h2l_sig),
        .tx_sig     (tx_sig),
        .tx_data    (tx_data),
        .len        (len),
        .tx_pin_out (tx_pin_out),
        .tx_busy    (tx_busy),
        .tx_done_sig(tx_done_sig)
    );

    // Pulse counters; tasks compare deltas against snapshots
    always @(posedge clk) begin
        if (rx_done_sig) rx_done_cnt <= rx_done_cnt + 1;
        if (h2l_sig)     h2l_cnt     <= h2l_cnt + 1;
        if (tx_done_sig) tx_done_cnt <= tx_done_cnt + 1;
    end

    task automatic send_rx_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = stop;
        repeat (CPB) @(negedge clk);
    endtask

    // Starts a tx frame and samples the line mid-bit; optional poke retriggers mid-frame
    task automatic tx_capture(input logic [63:0] data, input logic [3:0] n, input int nbits,
                              input bit poke, output logic [79:0] bits,
                              output logic busy_first, output logic busy_last,
                              output logic done_end, output logic busy_end,
                              output logic done_after);
        @(negedge clk);
        tx_data = data;
        len     = n;
        tx_sig  = 1'b1;
        @(posedge clk);
        #1;
        busy_first = tx_busy;
        bits = '1;
        for (int b = 0; b < nbits; b++) begin
            repeat ((b == 0) ? 8 : CPB) @(posedge clk);
            #1;
            bits[b] = tx_pin_out;
            if (poke && b == 3) tx_sig = 1'b0;
            if (poke && b == 12) begin
                tx_sig  = 1'b1;
                tx_data = 64'hDEAD_BEEF_CAFE_F00D;
                len     = 4'd8;
            end
        end
        busy_last = tx_busy;
        repeat (8) @(posedge clk);
        #1;
        done_end = tx_done_sig;
        busy_end = tx_busy;
        @(posedge clk);
        #1;
        done_after = tx_done_sig;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_vec++;
        if (tx_pin_out !== 1'b1) begin
            n_err++; $display("FAIL reset_tx_pin: got %b expected 1", tx_pin_out);
        end
        n_vec++;
        if (rx_data !== 8'h00) begin
            n_err++; $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        end
        n_vec++;
        if (tx_busy !== 1'b0) begin
            n_err++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy);
        end
        n_vec++;
        if ({rx_done_sig, h2l_sig, tx_done_sig} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_pulses: got %b expected 000", {rx_done_sig, h2l_sig, tx_done_sig});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_rx();
        int d0, h0;
        d0 = rx_done_cnt;
        h0 = h2l_cnt;
        send_rx_byte(8'hA5, 1'b1);
        // Pulse must already have happened within the stop bit
        n_vec++;
        if (rx_done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL rx_a5_pulse: got %0d pulses expected 1", rx_done_cnt - d0);
        end
        n_vec++;
        if (rx_data !== 8'hA5) begin
            n_err++; $display("FAIL rx_a5_data: got %h expected a5", rx_data);
        end
        // A5 LSB-first: start edge plus three 1->0 transitions inside the data bits
        n_vec++;
        if (h2l_cnt - h0 !== 4) begin
            n_err++; $display("FAIL rx_a5_h2l: got %0d edges expected 4", h2l_cnt - h0);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_rx_glitch_framing();
        int d0, h0;
        d0 = rx_done_cnt;
        h0 = h2l_cnt;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        n_vec++;
        if (rx_done_cnt - d0 !== 0) begin
            n_err++; $display("FAIL rx_glitch_pulse: got %0d pulses expected 0", rx_done_cnt - d0);
        end
        n_vec++;
        if (h2l_cnt - h0 !== 1) begin
            n_err++; $display("FAIL rx_glitch_h2l: got %0d edges expected 1", h2l_cnt - h0);
        end
        d0 = rx_done_cnt;
        h0 = h2l_cnt;
        send_rx_byte(8'h3C, 1'b0);
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        n_vec++;
        if (rx_done_cnt - d0 !== 0) begin
            n_err++; $display("FAIL rx_framing_pulse: got %0d pulses expected 0", rx_done_cnt - d0);
        end
        n_vec++;
        if (rx_data !== 8'hA5) begin
            n_err++; $display("FAIL rx_framing_data: got %h expected a5", rx_data);
        end
        // 3C LSB-first: start edge plus one 1->0 transition
        n_vec++;
        if (h2l_cnt - h0 !== 2) begin
            n_err++; $display("FAIL rx_framing_h2l: got %0d edges expected 2", h2l_cnt - h0);
        end
    endtask

    task automatic test_tx_8bytes();
        logic [79:0] bits;
        logic bf, bl, de, be, da;
        logic [9:0] exp_frame;
        @(negedge clk);
        tx_sig = 1'b0;
        repeat (3) @(negedge clk);
        tx_capture(64'h0807060504030201, 4'd8, 80, 1'b0, bits, bf, bl, de, be, da);
        n_vec++;
        if (bf !== 1'b1) begin
            n_err++; $display("FAIL tx8_busy_start: got %b expected 1", bf);
        end
        for (int k = 0; k < 8; k++) begin
            exp_frame = {1'b1, 8'(k + 1), 1'b0};
            n_vec++;
            if (bits[10*k +: 10] !== exp_frame) begin
                n_err++;
                $display("FAIL tx8_byte%0d: got %b expected %b", k, bits[10*k +: 10], exp_frame);
            end
        end
        n_vec++;
        if (bl !== 1'b1) begin
            n_err++; $display("FAIL tx8_busy_last_bit: got %b expected 1", bl);
        end
        n_vec++;
        if ({de, be} !== 2'b10) begin
            n_err++; $display("FAIL tx8_done_at_1280: got done=%b busy=%b expected 1 0", de, be);
        end
        n_vec++;
        if (da !== 1'b0) begin
            n_err++; $display("FAIL tx8_done_width: got %b expected 0", da);
        end
        n_vec++;
        if (tx_pin_out !== 1'b1) begin
            n_err++; $display("FAIL tx8_idle_line: got %b expected 1", tx_pin_out);
        end
    endtask

    task automatic test_tx_len2_retrigger();
        logic [79:0] bits;
        logic bf, bl, de, be, da;
        int t0;
        @(negedge clk);
        tx_sig = 1'b0;
        repeat (3) @(negedge clk);
        t0 = tx_done_cnt;
        tx_capture(64'h0807060504030201, 4'd2, 20, 1'b1, bits, bf, bl, de, be, da);
        n_vec++;
        if (bits[9:0] !== {1'b1, 8'h01, 1'b0}) begin
            n_err++; $display("FAIL tx2_byte0: got %b expected 1000000010", bits[9:0]);
        end
        n_vec++;
        if (bits[19:10] !== {1'b1, 8'h02, 1'b0}) begin
            n_err++; $display("FAIL tx2_byte1: got %b expected 1000000100", bits[19:10]);
        end
        n_vec++;
        if ({de, be} !== 2'b10) begin
            n_err++; $display("FAIL tx2_done_at_320: got done=%b busy=%b expected 1 0", de, be);
        end
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if ({tx_busy, tx_pin_out} !== 2'b01) begin
            n_err++;
            $display("FAIL tx2_retrigger_dropped: got busy=%b pin=%b expected 0 1", tx_busy, tx_pin_out);
        end
        n_vec++;
        if (tx_done_cnt - t0 !== 1) begin
            n_err++; $display("FAIL tx2_done_count: got %0d expected 1", tx_done_cnt - t0);
        end
        tx_sig = 1'b0;
    endtask

    task automatic test_loopback();
        int d0;
        bit got;
        @(negedge clk);
        tx_sig  = 1'b0;
        loop_en = 1'b1;
        repeat (3) @(negedge clk);
        d0 = rx_done_cnt;
        tx_data = 64'h55;
        len     = 4'd1;
        tx_sig  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (rx_done_cnt != d0) got = 1'b1;
        end
        repeat (40) @(posedge clk);
        #1;
        n_vec++;
        if (rx_done_cnt - d0 !== 1) begin
            n_err++; $display("FAIL loop_pulse: got %0d pulses expected 1", rx_done_cnt - d0);
        end
        n_vec++;
        if (rx_data !== 8'h55) begin
            n_err++; $display("FAIL loop_data: got %h expected 55", rx_data);
        end
        loop_en = 1'b0;
        tx_sig  = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        tx_sig = 1'b0;
        repeat (3) @(negedge clk);
        tx_data = '0;
        len     = 4'd8;
        tx_sig  = 1'b1;
        repeat (40) @(negedge clk);
        n_vec++;
        if ({tx_busy, tx_pin_out} !== 2'b10) begin
            n_err++;
            $display("FAIL abort_mid_frame: got busy=%b pin=%b expected 1 0", tx_busy, tx_pin_out);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tx_busy, tx_pin_out} !== 2'b01) begin
            n_err++;
            $display("FAIL abort_in_reset: got busy=%b pin=%b expected 0 1", tx_busy, tx_pin_out);
        end
        tx_sig = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (tx_busy !== 1'b0) begin
            n_err++; $display("FAIL abort_after_release: got %b expected 0", tx_busy);
        end
    endtask

    initial begin
        test_reset();
        test_rx();
        test_rx_glitch_framing();
        test_tx_8bytes();
        test_tx_len2_retrigger();
        test_loopback();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
